// File: rtl/regfile_read_arbiter_if.sv
// Requester-side bundle for regfile_read_arbiter: two request ports plus the shared response beat.
interface regfile_read_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) ();
  logic              req0_valid;
  logic              req0_lock;
  logic [ADDR_W-1:0] req0_addr1;
  logic [ADDR_W-1:0] req0_addr2;
  logic              req0_ready;
  logic              req1_valid;
  logic              req1_lock;
  logic [ADDR_W-1:0] req1_addr1;
  logic [ADDR_W-1:0] req1_addr2;
  logic              req1_ready;
  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data1;
  logic [DATA_W-1:0] rsp_data2;

  modport master (
    output req0_valid, req0_lock, req0_addr1, req0_addr2,
    output req1_valid, req1_lock, req1_addr1, req1_addr2,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data1, rsp_data2
  );

  modport slave (
    input  req0_valid, req0_lock, req0_addr1, req0_addr2,
    input  req1_valid, req1_lock, req1_addr1, req1_addr2,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data1, rsp_data2
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Two-requester arbiter for the register-file read ports, with lock and 2-cycle tagged response.
// Define RF_ARB_FIXED_PRIO_EN to make ties always go to port 0 instead of round-robin.
module regfile_read_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_read_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0]      rf_raddr1,
  output logic [ADDR_W-1:0]      rf_raddr2,
  input  logic [DATA_W-1:0]      rf_rdata1,
  input  logic [DATA_W-1:0]      rf_rdata2
);

  typedef enum logic [1:0] {StRr, StLock0, StLock1} state_e;

  state_e            state_q, state_d;
  logic              gnt0, gnt1;
  logic              tie_to0;
  logic              iss_v_q, iss_id_q;
  logic              rsp_valid_q, rsp_id_q;
  logic [DATA_W-1:0] rsp_data1_q, rsp_data2_q;

`ifdef RF_ARB_FIXED_PRIO_EN
  assign tie_to0 = 1'b1;
`else
  logic last_grant_q;

  // last_grant names the most recent winner; a tie goes to the other port
  assign tie_to0 = last_grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (gnt1) begin
      last_grant_q <= 1'b1;
    end else if (gnt0) begin
      last_grant_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRr;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (gnt0) begin
      state_d = bus.req0_lock ? StLock0 : StRr;
    end else if (gnt1) begin
      state_d = bus.req1_lock ? StLock1 : StRr;
    end
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (state_q)
        StRr: begin
          gnt0 = bus.req0_valid && (!bus.req1_valid || tie_to0);
          gnt1 = bus.req1_valid && (!bus.req0_valid || !tie_to0);
        end
        StLock0: gnt0 = bus.req0_valid;
        StLock1: gnt1 = bus.req1_valid;
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign rf_raddr1 = gnt0 ? bus.req0_addr1 : (gnt1 ? bus.req1_addr1 : '0);
  assign rf_raddr2 = gnt0 ? bus.req0_addr2 : (gnt1 ? bus.req1_addr2 : '0);

  // Tag travels alongside the register file's one-cycle read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      iss_v_q     <= 1'b0;
      iss_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
    end else begin
      iss_v_q     <= gnt0 | gnt1;
      iss_id_q    <= gnt1;
      rsp_valid_q <= iss_v_q;
      rsp_id_q    <= iss_id_q;
      rsp_data1_q <= rf_rdata1;
      rsp_data2_q <= rf_rdata2;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data1 = rsp_data1_q;
  assign bus.rsp_data2 = rsp_data2_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Randomised scoreboard bench for regfile_read_arbiter with a behavioural register file.
module tb_regfile_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [31:0] mem [32];

  regfile_read_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_read_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rf_rdata1 <= mem[rf_raddr1];
    rf_rdata2 <= mem[rf_raddr2];
  end

  typedef struct {
    bit          id;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_lock;
  bit   m_last;
  bit   g0, g1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: who may be granted this cycle, from the arbitration rules directly
  task automatic model_check();
    bit e0, e1;
    logic [4:0] ea1, ea2;
    exp_t x;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!reset) begin
      if (m_lock == 0) e0 = bus.req0_valid;
      else if (m_lock == 1) e1 = bus.req1_valid;
      else if (bus.req0_valid && bus.req1_valid) begin
`ifdef RF_ARB_FIXED_PRIO_EN
        e0 = 1'b1;
`else
        if (m_last) e0 = 1'b1;
        else e1 = 1'b1;
`endif
      end else begin
        e0 = bus.req0_valid;
        e1 = bus.req1_valid;
      end
    end
    ea1 = e0 ? bus.req0_addr1 : (e1 ? bus.req1_addr1 : 5'd0);
    ea2 = e0 ? bus.req0_addr2 : (e1 ? bus.req1_addr2 : 5'd0);
    chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, e0});
    chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, e1});
    chk("rf_raddr1", {27'd0, rf_raddr1}, {27'd0, ea1});
    chk("rf_raddr2", {27'd0, rf_raddr2}, {27'd0, ea2});
    if (e0 || e1) begin
      x.id = e1;
      x.d1 = (ea1 == 5'd0) ? 32'd0 : mem[ea1];
      x.d2 = (ea2 == 5'd0) ? 32'd0 : mem[ea2];
      exp_q.push_back(x);
      m_last = e1;
      if (e0) m_lock = bus.req0_lock ? 0 : -1;
      else m_lock = bus.req1_lock ? 1 : -1;
    end
    if (reset) begin
      m_lock = -1;
      m_last = 1'b1;
    end
    g0 = e0;
    g1 = e1;
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v0, input bit l0, input int a01, input int a02,
                       input bit v1, input bit l1, input int a11, input int a12);
    bus.req0_valid = v0;
    bus.req0_lock  = l0;
    bus.req0_addr1 = 5'(a01);
    bus.req0_addr2 = 5'(a02);
    bus.req1_valid = v1;
    bus.req1_lock  = l1;
    bus.req1_addr1 = 5'(a11);
    bus.req1_addr2 = 5'(a12);
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {31'd0, bus.rsp_valid}, 32'd0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("rsp_id", {31'd0, bus.rsp_id}, {31'd0, x.id});
        chk("rsp_data1", bus.rsp_data1, x.d1);
        chk("rsp_data2", bus.rsp_data2, x.d2);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1111_1111 * i;
    for (int i = 16; i < 31; i++) mem[i] = $urandom;
    mem[31] = 32'h0;
    m_lock = -1;
    m_last = 1'b1;
    reset  = 1'b1;
    drive(1, 0, 1, 2, 1, 0, 3, 4);
    @(posedge clk);
    #1;
    step();
    step();
    chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    chk("reset_rsp_data1", bus.rsp_data1, 32'd0);
    chk("reset_rsp_data2", bus.rsp_data2, 32'd0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    // Single read, then register 0 with register 15
    drive(1, 0, 5, 10, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 15, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Tie: both valid four cycles
    drive(1, 0, 1, 2, 1, 0, 3, 31);
    repeat (4) step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Lock: req0 alone first so the tie then favours req1, which locks for 3 beats
    drive(1, 0, 7, 8, 0, 0, 0, 0);
    step();
    drive(1, 0, 7, 8, 1, 1, 9, 11);
    repeat (3) step();
    drive(1, 0, 7, 8, 1, 0, 9, 11);
    step();
    drive(1, 0, 7, 8, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Reset mid-flight: the accepted beat must never respond
    drive(1, 0, 5, 10, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midreset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    drive(1, 0, 12, 13, 1, 0, 14, 3);
    repeat (3) step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Random traffic, holding each request until the model says it was accepted
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    g0 = 1'b0;
    g1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.req0_valid || g0) begin
        bus.req0_valid = ($urandom_range(0, 3) != 0);
        bus.req0_lock  = ($urandom_range(0, 3) == 0);
        bus.req0_addr1 = 5'($urandom_range(0, 31));
        bus.req0_addr2 = 5'($urandom_range(0, 31));
      end
      if (!bus.req1_valid || g1) begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        bus.req1_lock  = ($urandom_range(0, 3) == 0);
        bus.req1_addr1 = 5'($urandom_range(0, 31));
        bus.req1_addr2 = 5'($urandom_range(0, 31));
      end
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) step();
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Shares the two read ports of the 32×32 register file between two requesters: port 0 (decode) and port 1 (debug/scan). Each accepted request reads two registers in one access; the arbiter issues at most one access per cycle to the register file, tags it, and routes the read data back to the owning requester. It sits between the requesters and the register file, which samples its read addresses on each `clk` edge and returns registered data one cycle later.

## Interface
- `ADDR_W`, 5, register address width
- `DATA_W`, 32, register data width

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `req0_valid`, `req1_valid`  in  1  request present
- `req0_lock`, `req1_lock`  in  1  keep grant after this beat
- `req0_addr1`, `req0_addr2`, `req1_addr1`, `req1_addr2`  in  ADDR_W  register numbers
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle (combinational)
- `rf_raddr1`, `rf_raddr2`  out  ADDR_W  to register file read ports
- `rf_rdata1`, `rf_rdata2`  in  DATA_W  register file registered read data
- `rsp_valid`  out  1  response beat
- `rsp_id`  out  1  owning requester
- `rsp_data1`, `rsp_data2`  out  DATA_W  read data

## Operation
- A beat is accepted when `reqN_valid && reqN_ready`. Requests with valid=1 must hold their addresses and lock until accepted.
- Grant FSM states: RR, LOCK0, LOCK1. Reset state is RR.
- **RR**:
  - With a single valid request, that request is granted.
  - With both valid, the requester not named by `last_grant` is granted.
  - `last_grant` updates on every accept and resets to 1, so port 0 wins the first tie.
- A granted beat with `lock=1` moves the FSM to LOCKn. In LOCKn, only requester n may be granted; the other `ready` is 0.
- In LOCKn, a granted beat with `lock=0` returns the FSM to RR after that beat. A lock held without valid keeps the lock (no timeout).
- `rf_raddr1/2` = granted requester's addresses. When there is no grant, both are 0.
- Issue stage registers: `iss_v`, `iss_id`.
- Response registers capture `rf_rdata1/2` together with `iss_v`/`iss_id`. Data passes through unmodified; register 0 reads as 0 by register-file behaviour.
- There is no response backpressure. Requesters must sink every `rsp_valid` beat.

## Timing
- Cycle T: accept. Cycle T+1: `rf_rdata` valid. Cycle T+2: `rsp_valid=1`, `rsp_id`, and `rsp_data` visible. Latency is 2 cycles.
- Throughput is 1 beat/cycle. Back-to-back accepts produce back-to-back responses, in order.
- `ready` depends combinationally on valid and FSM state only, never on `ready`.
- Reset values: `rsp_valid=0`, `rsp_id=0`, `rsp_data1/2=0`, `iss_v=0`, FSM=RR, `last_grant=1`.
- Under reset, `reqN_ready=0` and `rf_raddr1/2=0`.
- Reset asserted mid-flight discards all in-flight beats. `rsp_valid` is 0 from the cycle after the reset edge.
- Lock acquire and release take effect on the cycle after the accepting edge.

## Configuration
- `RF_ARB_FIXED_PRIO_EN` defined: RR state uses fixed priority (port 0 always wins a tie) and `last_grant` is unused. Lock behaviour is unchanged.
- `RF_ARB_FIXED_PRIO_EN` undefined: round-robin as described above.

## Test plan
- **Single read:** register file freshly reset, req0 (5,10) at T → T+2 `rsp_id=0`, data1=0x55555555, data2=0xAAAAAAAA.
- **Tie round-robin:** both valid for 4 cycles, req0 (1,2), req1 (3,31) → grants 0,1,0,1; responses T+2..T+5 alternate, req1 returns 0x33333333/0x00000000.
- **Lock:** req1 lock=1 for 3 beats then lock=0, with req0 valid throughout → `req0_ready=0` for those 4 beats; req0 granted on the next cycle.
- **Register 0:** req0 (0,15) → data1=0x00000000, data2=0xFFFFFFFF.
- **Reset mid-flight:** accept at T, `reset` at T+1 → no `rsp_valid` at T+2; FSM=RR; tie afterwards grants port 0.
- **`RF_ARB_FIXED_PRIO_EN`:** both valid for 3 cycles → all grants go to port 0; `req1_ready` stays 0.
